// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op encodings, FSM states and flag bit positions.
// Pure declarations: no latency, no backpressure.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_SLTU = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        OUT_HOLD = 2'd2
    } alu_state_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;

    function automatic logic [3:0] mk_flags(input logic err, input logic ovf,
                                            input logic carry, input logic zero);
        logic [3:0] f;
        f             = '0;
        f[FLAG_ERR]   = err;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per cycle; done pulses on the last iteration
// with prod valid in that same cycle (ITERS cycles after start). No backpressure: caller must consume on done.
module alu_mul_seq #(
    parameter int WORD_SIZE = 8,
    parameter int ITERS     = WORD_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WORD_SIZE-1:0]   a,
    input  logic [WORD_SIZE-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [2*WORD_SIZE-1:0] prod
);
    localparam int CW = $clog2(ITERS) + 1;

    logic [2*WORD_SIZE-1:0] mcand;
    logic [2*WORD_SIZE-1:0] acc;
    logic [2*WORD_SIZE-1:0] acc_nxt;
    logic [WORD_SIZE-1:0]   mplier;
    logic [CW-1:0]          cnt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    // prod is the accumulator as it will be after this cycle's step, so the
    // final product is available combinationally alongside done.
    assign done    = busy && (cnt == CW'(ITERS - 1));
    assign prod    = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WORD_SIZE{1'b0}}, a};
            acc    <= '0;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU: single-cycle ops land in the output registers on accept (latency 1), MUL iterates WORD_SIZE cycles (latency WORD_SIZE+1).
// Result is held until out_ready; a drain and a new accept may share a cycle, giving 1 result/cycle for non-MUL ops.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int MUL_CYCLES = WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [WORD_SIZE-1:0] in1,
    input  logic [WORD_SIZE-1:0] in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out,
    output logic [WORD_SIZE-1:0] out_hi,
    output logic [3:0]           flags
);
    localparam int SHW = $clog2(WORD_SIZE);

    alu_state_e state;

    logic                   accept;
    logic                   mul_start;
    logic                   mul_busy;
    logic                   mul_done;
    logic [2*WORD_SIZE-1:0] mul_prod;
    logic [WORD_SIZE-1:0]   mul_lo;
    logic [WORD_SIZE-1:0]   mul_hi;

    logic [SHW-1:0]         sh;
    logic [WORD_SIZE:0]     sum;
    logic [WORD_SIZE:0]     diff;
    logic [WORD_SIZE-1:0]   alu_res;
    logic                   alu_carry;
    logic                   alu_ovf;
    logic                   alu_err;

    // Gated by rst_n so upstream never sees a ready while the block is held in reset.
    assign in_ready  = rst_n && ((state == IDLE) || ((state == OUT_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(
        .WORD_SIZE (WORD_SIZE),
        .ITERS     (MUL_CYCLES)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (in1),
        .b     (in2),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign mul_lo = mul_prod[WORD_SIZE-1:0];
    assign mul_hi = mul_prod[2*WORD_SIZE-1:WORD_SIZE];

    assign sh   = in2[SHW-1:0];
    assign sum  = {1'b0, in1} + {1'b0, in2};
    assign diff = {1'b0, in1} - {1'b0, in2};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[WORD_SIZE-1:0];
                alu_carry = sum[WORD_SIZE];
                alu_ovf   = (in1[WORD_SIZE-1] == in2[WORD_SIZE-1]) &&
                            (sum[WORD_SIZE-1] != in1[WORD_SIZE-1]);
            end
            OP_SUB: begin
                alu_res   = diff[WORD_SIZE-1:0];
                alu_carry = diff[WORD_SIZE];
                alu_ovf   = (in1[WORD_SIZE-1] != in2[WORD_SIZE-1]) &&
                            (diff[WORD_SIZE-1] != in1[WORD_SIZE-1]);
            end
            OP_MUL:  alu_res    = '0;
            OP_SLT:  alu_res[0] = $signed(in1) < $signed(in2);
            OP_SLTU: alu_res[0] = in1 < in2;
            OP_AND:  alu_res    = in1 & in2;
            OP_OR:   alu_res    = in1 | in2;
            OP_XOR:  alu_res    = in1 ^ in2;
            OP_SLL:  alu_res    = in1 << sh;
            OP_SRL:  alu_res    = in1 >> sh;
            OP_SRA:  alu_res    = $signed(in1) >>> sh;
            default: alu_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            out_hi    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE, OUT_HOLD: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state     <= MUL_BUSY;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= OUT_HOLD;
                            out_valid <= 1'b1;
                            out       <= alu_res;
                            out_hi    <= '0;
                            flags     <= mk_flags(alu_err, alu_ovf, alu_carry, alu_res == '0);
                        end
                    end else if ((state == OUT_HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state     <= OUT_HOLD;
                        out_valid <= 1'b1;
                        out       <= mul_lo;
                        out_hi    <= mul_hi;
                        flags     <= mk_flags(1'b0, mul_hi != '0, 1'b0, mul_prod == '0);
                    end else if (!mul_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vector bench for alu_pipe at WORD_SIZE=8: table of single ops plus
// hand sequences for back-to-back throughput, output hold, drain+MUL and reset mid-MUL.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] in1, in2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out, out_hi;
    logic [3:0] flags;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] e_out;
        logic [7:0] e_hi;
        logic [3:0] e_flags;
        int         e_lat;
    } vec_t;

    vec_t vt [19];

    alu_pipe #(.WORD_SIZE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_hi    (out_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request with out_ready held high, wait for the result, then confirm drain.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit rdy_while_busy;
        @(negedge clk);
        in_valid  = 1'b1;
        op        = v.op;
        in1       = v.a;
        in2       = v.b;
        out_ready = 1'b1;
        #1 check($sformatf("v%0d issue_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid       = 1'b0;
        lat            = 1;
        rdy_while_busy = 1'b0;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_while_busy = 1'b1;
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, v.e_lat);
        check($sformatf("v%0d out", idx), out, v.e_out);
        check($sformatf("v%0d out_hi", idx), out_hi, v.e_hi);
        check($sformatf("v%0d flags", idx), flags, v.e_flags);
        check($sformatf("v%0d busy_ready", idx), rdy_while_busy, 0);
        @(negedge clk);
        check($sformatf("v%0d drained", idx), out_valid, 0);
    endtask

    initial begin : main
        logic [7:0] xa [4];
        logic [7:0] xb [4];
        logic [7:0] xe [4];
        int  lat;
        bit  seen_valid;

        //        op       a      b      out    hi     {e,o,c,z} lat
        vt[0]  = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1};
        vt[1]  = '{OP_SUB,  8'h7F, 8'hFF, 8'h80, 8'h00, 4'b0110, 1};
        vt[2]  = '{OP_SLT,  8'hFF, 8'h01, 8'h01, 8'h00, 4'b0000, 1};
        vt[3]  = '{OP_SLTU, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0001, 1};
        vt[4]  = '{OP_SRA,  8'h90, 8'h09, 8'hC8, 8'h00, 4'b0000, 1};
        vt[5]  = '{4'hF,    8'h12, 8'h34, 8'h00, 8'h00, 4'b1001, 1};
        vt[6]  = '{OP_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 4'b0100, 1};
        vt[7]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1};
        vt[8]  = '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0000, 1};
        vt[9]  = '{OP_XOR,  8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001, 1};
        vt[10] = '{OP_SLL,  8'h81, 8'h0A, 8'h04, 8'h00, 4'b0000, 1};
        vt[11] = '{OP_SRL,  8'h81, 8'h03, 8'h10, 8'h00, 4'b0000, 1};
        vt[12] = '{OP_SUB,  8'h05, 8'h05, 8'h00, 8'h00, 4'b0001, 1};
        vt[13] = '{OP_SLT,  8'h01, 8'hFF, 8'h00, 8'h00, 4'b0001, 1};
        vt[14] = '{4'hB,    8'h01, 8'h01, 8'h00, 8'h00, 4'b1001, 1};
        vt[15] = '{OP_MUL,  8'hC8, 8'h03, 8'h58, 8'h02, 4'b0100, 9};
        vt[16] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0100, 9};
        vt[17] = '{OP_MUL,  8'h00, 8'h37, 8'h00, 8'h00, 4'b0001, 9};
        vt[18] = '{OP_MUL,  8'h0F, 8'h0F, 8'hE1, 8'h00, 4'b0000, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        in1       = 8'h00;
        in2       = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        check("rst out", out, 0);
        check("rst out_hi", out_hi, 0);
        check("rst flags", flags, 0);
        rst_n = 1'b1;
        #1 check("rst release in_ready", in_ready, 1);

        for (int i = 0; i < 19; i++) begin
            run_vec(i, vt[i]);
        end

        // Back-to-back XOR stream, then output hold under out_ready=0.
        xa = '{8'h11, 8'h22, 8'h33, 8'h44};
        xb = '{8'hFF, 8'h0F, 8'hF0, 8'h44};
        xe = '{8'hEE, 8'h2D, 8'hC3, 8'h00};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            op       = OP_XOR;
            in1      = xa[i];
            in2      = xb[i];
            #1 check($sformatf("b2b%0d ready", i), in_ready, 1);
            @(negedge clk);
            check($sformatf("b2b%0d valid", i), out_valid, 1);
            check($sformatf("b2b%0d out", i), out, xe[i]);
        end
        in_valid  = 1'b1;
        op        = OP_ADD;
        in1       = 8'h01;
        in2       = 8'h01;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("hold%0d in_ready", i), in_ready, 0);
            @(negedge clk);
            check($sformatf("hold%0d valid", i), out_valid, 1);
            check($sformatf("hold%0d out", i), out, 8'h00);
            check($sformatf("hold%0d flags", i), flags, 4'b0001);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("hold release drained", out_valid, 0);

        // Drain coinciding with a MUL accept drops out_valid.
        in_valid = 1'b1;
        op       = OP_ADD;
        in1      = 8'h01;
        in2      = 8'h01;
        @(negedge clk);
        check("pre-mul add out", out, 8'h02);
        op  = OP_MUL;
        in1 = 8'h03;
        in2 = 8'h04;
        #1 check("drain+mul ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain+mul valid", out_valid, 0);
        #1 check("drain+mul busy ready", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("drain+mul latency", lat, 9);
        check("drain+mul out", out, 8'h0C);
        @(negedge clk);

        // Reset asserted in the 4th busy cycle of a MUL: result must be discarded.
        in_valid = 1'b1;
        op       = OP_MUL;
        in1      = 8'hC8;
        in2      = 8'h03;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midmul rst out_valid", out_valid, 0);
        check("midmul rst out", out, 0);
        check("midmul rst in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midmul release in_ready", in_ready, 1);
        seen_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midmul discarded", seen_valid, 0);
        run_vec(100, '{OP_ADD, 8'h02, 8'h03, 8'h05, 8'h00, 4'b0000, 1});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
